// File: rtl/multichannel_average_filter.sv
// Time-multiplexed moving-average (boxcar) filter for NUM_CH interleaved signed
// sample streams. Each channel keeps its own circular history, fill count,
// write pointer and running accumulator. The window is 2^win_active samples,
// and the output is acc >>> win_active.
//
// Optional build macro: AVG_ROUND_NEAREST_EN. When it is defined, the output
// rounds half toward +inf. When it is undefined, the output is floored.
//
// Ports:
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   in_valid    : sample strobe; there is no backpressure
//   in_ch       : channel of in_data; indices >= NUM_CH are dropped
//   in_data     : signed input sample
//   win_log2    : requested window log2; values above MAX_LOG2_WIN clamp
//   flush       : clears all channel state on the next edge
//                 and kills samples in flight
//   out_valid   : one pulse per surviving sample, 2 cycles after acceptance
//   out_ch      : channel of out_data
//   out_data    : signed windowed average
//   win_active  : window log2 currently applied
module multichannel_average_filter #(
    parameter  int unsigned DATA_WIDTH       = 12,
    parameter  int unsigned NUM_CH           = 2,
    parameter  int unsigned MAX_LOG2_WIN     = 5,
    parameter  int unsigned DEFAULT_LOG2_WIN = 4,
    localparam int unsigned ACC_WIDTH        = DATA_WIDTH + MAX_LOG2_WIN,
    localparam int unsigned CH_W             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned WL_W             = $clog2(MAX_LOG2_WIN + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [CH_W-1:0]              in_ch,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic [WL_W-1:0]              win_log2,
    input  logic                         flush,
    output logic                         out_valid,
    output logic [CH_W-1:0]              out_ch,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic [WL_W-1:0]              win_active
);

    localparam int unsigned DEPTH = 1 << MAX_LOG2_WIN;
    localparam int unsigned PTR_W = MAX_LOG2_WIN;
    localparam int unsigned CNT_W = MAX_LOG2_WIN + 1;

    // Per-channel state
    logic signed [DATA_WIDTH-1:0] hist [NUM_CH][DEPTH];
    logic [PTR_W-1:0]             wptr [NUM_CH];
    logic [CNT_W-1:0]             fill [NUM_CH];
    logic signed [ACC_WIDTH-1:0]  acc  [NUM_CH];

    // Stage 1 (accumulate) registers
    logic                         s1_valid;
    logic [CH_W-1:0]              s1_ch;
    logic signed [DATA_WIDTH-1:0] s1_x;
    logic signed [DATA_WIDTH-1:0] s1_old;

    logic [WL_W-1:0]              win_req_c;
    logic                         win_change_c;
    logic                         clear_c;
    logic                         accept_c;
    logic [CNT_W-1:0]             win_len_c;
    logic [PTR_W-1:0]             rd_ptr_c;
    logic signed [DATA_WIDTH-1:0] old_c;
    logic signed [ACC_WIDTH-1:0]  acc_new_c;
    logic signed [ACC_WIDTH:0]    acc_ext_c;
    logic signed [DATA_WIDTH-1:0] avg_c;
`ifdef AVG_ROUND_NEAREST_EN
    logic signed [ACC_WIDTH:0]    bias_c;
`endif

    // Stage 0: qualify the sample and fetch the sample leaving the window.
    // History, pointer and fill count all update at the accept edge, so a
    // same-channel sample on the next cycle already sees them.
    always_comb begin
        win_req_c    = (win_log2 > WL_W'(MAX_LOG2_WIN)) ? WL_W'(MAX_LOG2_WIN) : win_log2;
        // The stage-1 sample retires on this same edge with the old window.
        win_change_c = !in_valid && (win_req_c != win_active);
        clear_c      = flush || win_change_c;
        accept_c     = in_valid && !flush && ({1'b0, in_ch} < (CH_W + 1)'(NUM_CH));
        win_len_c    = CNT_W'(1) << win_active;
        // When the window equals the full depth, this wraps onto the slot
        // about to be overwritten.
        rd_ptr_c     = wptr[in_ch] - win_len_c[PTR_W-1:0];
        old_c        = (fill[in_ch] >= win_len_c) ? hist[in_ch][rd_ptr_c] : '0;
    end

    // Stage 1: update the running sum. The accumulator is read and written in
    // this one stage, so back-to-back samples on a channel need no forwarding.
    always_comb begin
        acc_new_c = acc[s1_ch] + ACC_WIDTH'(s1_x) - ACC_WIDTH'(s1_old);
`ifdef AVG_ROUND_NEAREST_EN
        bias_c    = '0;
        if (win_active != '0) begin
            bias_c = (ACC_WIDTH + 1)'(1) << (win_active - WL_W'(1));
        end
        acc_ext_c = (ACC_WIDTH + 1)'(acc_new_c) + bias_c;
`else
        acc_ext_c = (ACC_WIDTH + 1)'(acc_new_c);
`endif
        avg_c     = DATA_WIDTH'(acc_ext_c >>> win_active);
    end

    // History RAM: this storage is deliberately not reset.
    // The fill count keeps stale entries from ever being used.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            hist[in_ch][wptr[in_ch]] <= in_data;
        end
    end

    // Pipeline, channel state and window control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_active <= WL_W'(DEFAULT_LOG2_WIN);
            s1_valid   <= 1'b0;
            s1_ch      <= '0;
            s1_x       <= '0;
            s1_old     <= '0;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_data   <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                acc[i]  <= '0;
                fill[i] <= '0;
                wptr[i] <= '0;
            end
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                s1_ch  <= in_ch;
                s1_x   <= in_data;
                s1_old <= old_c;
            end

            out_valid <= s1_valid && !flush;
            if (s1_valid) begin
                out_ch   <= s1_ch;
                out_data <= avg_c;
            end

            if (win_change_c) begin
                win_active <= win_req_c;
            end

            if (clear_c) begin
                for (int i = 0; i < int'(NUM_CH); i++) begin
                    acc[i]  <= '0;
                    fill[i] <= '0;
                    wptr[i] <= '0;
                end
            end else begin
                if (accept_c) begin
                    wptr[in_ch] <= wptr[in_ch] + PTR_W'(1);
                    if (fill[in_ch] < win_len_c) begin
                        fill[in_ch] <= fill[in_ch] + CNT_W'(1);
                    end
                end
                if (s1_valid) begin
                    acc[s1_ch] <= acc_new_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_multichannel_average_filter.sv
// Self-checking bench for multichannel_average_filter.
// The bench runs a directed vector table first, then random traffic.
// A transaction-level reference model checks every cycle against
// the windowed sum of each channel's recent samples.
module tb_multichannel_average_filter;

    localparam int DW   = 12;
    localparam int NCH  = 2;
    localparam int MAXL = 5;
    localparam int DEFL = 4;
    localparam int CHW  = 1;
    localparam int WLW  = 3;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic [CHW-1:0]       in_ch;
    logic signed [DW-1:0] in_data;
    logic [WLW-1:0]       win_log2;
    logic                 flush;
    logic                 out_valid;
    logic [CHW-1:0]       out_ch;
    logic signed [DW-1:0] out_data;
    logic [WLW-1:0]       win_active;

    multichannel_average_filter #(
        .DATA_WIDTH      (DW),
        .NUM_CH          (NCH),
        .MAX_LOG2_WIN    (MAXL),
        .DEFAULT_LOG2_WIN(DEFL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .win_log2  (win_log2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .win_active(win_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    // Reference model state
    typedef struct { int due; int ch; int val; } exp_t;
    exp_t exp_q[$];
    int   hist_q[NCH][$];
    int   m_win = DEFL;

    typedef struct {
        logic v; int ch; int d; int wl; logic fl;
        logic ev; int ech; int ed; int ew;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, edge_n);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q--;
        return q;
    endfunction

    function automatic int model_avg(input int ch);
        int w, sz, sum;
        w   = 1 << m_win;
        sz  = hist_q[ch].size();
        sum = 0;
        for (int i = 0; i < w && i < sz; i++) sum += hist_q[ch][sz-1-i];
`ifdef AVG_ROUND_NEAREST_EN
        return floor_div(sum + w / 2, w);
`else
        return floor_div(sum, w);
`endif
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) hist_q[c].delete();
    endtask

    // Apply the inputs that the DUT just sampled on edge edge_n.
    task automatic model_update(input logic v, input int ch, input int d, input int wl, input logic fl);
        int req;
        exp_t e;
        req = (wl > MAXL) ? MAXL : wl;
        if (fl) begin
            for (int i = exp_q.size() - 1; i >= 0; i--)
                if (exp_q[i].due == edge_n) exp_q.delete(i);
        end
        if (!v && req != m_win) begin
            m_win = req;
            model_clear();
        end
        if (fl) begin
            model_clear();
        end else if (v && ch < NCH) begin
            hist_q[ch].push_back(d);
            if (hist_q[ch].size() > (1 << MAXL)) void'(hist_q[ch].pop_front());
            e.due = edge_n + 1;
            e.ch  = ch;
            e.val = model_avg(ch);
            exp_q.push_back(e);
        end
    endtask

    task automatic model_check();
        logic ev;
        exp_t e;
        ev = (exp_q.size() > 0) && (exp_q[0].due == edge_n);
        check("out_valid", int'(out_valid), int'(ev));
        if (ev) begin
            e = exp_q.pop_front();
            check("out_ch", int'(out_ch), e.ch);
            check("out_data", int'(out_data), e.val);
        end
        check("win_active", int'(win_active), m_win);
    endtask

    task automatic drive_cycle(input logic v, input int ch, input int d, input int wl, input logic fl);
        in_valid = v;
        in_ch    = CHW'(ch);
        in_data  = DW'(d);
        win_log2 = WLW'(wl);
        flush    = fl;
        @(posedge clk);
        edge_n++;
        model_update(v, ch, d, wl, fl);
        #1;
        model_check();
    endtask

    task automatic add(input logic v, input int ch, input int d, input int wl, input logic fl,
                       input logic ev, input int ech, input int ed, input int ew);
        vec_t r;
        r.v = v; r.ch = ch; r.d = d; r.wl = wl; r.fl = fl;
        r.ev = ev; r.ech = ech; r.ed = ed; r.ew = ew;
        tbl.push_back(r);
    endtask

    initial begin
        int r1, r2, r3;
        int wl_r;
        logic v_r, fl_r;
`ifdef AVG_ROUND_NEAREST_EN
        r1 = 2;  r2 = -1; r3 = -1;
`else
        r1 = 1;  r2 = -2; r3 = -2;
`endif
        // Each row gives the inputs for one cycle and the outputs
        // expected just after that cycle's edge.
        // Constant 100, W=4
        add(0,0,0,2,0, 0,0,0,2);
        add(1,0,100,2,0, 0,0,0,2);
        add(1,0,100,2,0, 1,0,25,2);
        add(1,0,100,2,0, 1,0,50,2);
        add(1,0,100,2,0, 1,0,75,2);
        add(0,0,0,2,0, 1,0,100,2);
        add(0,0,0,2,1, 0,0,0,2);
        // Interleaved +80 / -80
        add(1,0,80,2,0, 0,0,0,2);
        add(1,1,-80,2,0, 1,0,20,2);
        add(1,0,80,2,0, 1,1,-20,2);
        add(1,1,-80,2,0, 1,0,40,2);
        add(1,0,80,2,0, 1,1,-40,2);
        add(1,1,-80,2,0, 1,0,60,2);
        add(1,0,80,2,0, 1,1,-60,2);
        add(1,1,-80,2,0, 1,0,80,2);
        add(1,0,80,2,0, 1,1,-80,2);
        add(1,1,-80,2,0, 1,0,80,2);
        add(0,0,0,2,0, 1,1,-80,2);
        add(0,0,0,2,1, 0,0,0,2);
        // Back-to-back same channel
        add(1,0,0,2,0, 0,0,0,2);
        add(1,0,0,2,0, 1,0,0,2);
        add(1,0,0,2,0, 1,0,0,2);
        add(1,0,0,2,0, 1,0,0,2);
        add(1,0,64,2,0, 1,0,0,2);
        add(1,0,64,2,0, 1,0,16,2);
        add(1,0,64,2,0, 1,0,32,2);
        add(1,0,64,2,0, 1,0,48,2);
        add(0,0,0,2,0, 1,0,64,2);
        add(0,0,0,2,1, 0,0,0,2);
        // Window change deferred while valid is high
        add(1,0,8,3,0, 0,0,0,2);
        add(1,0,8,3,0, 1,0,2,2);
        add(1,0,8,3,0, 1,0,4,2);
        add(0,0,0,3,0, 1,0,6,3);
        add(1,0,8,3,0, 0,0,0,3);
        for (int i = 2; i <= 8; i++) add(1,0,8,3,0, 1,0,i-1,3);
        add(0,0,0,3,0, 1,0,8,3);
        add(0,0,0,3,0, 0,0,0,3);
        // Flush with samples in flight
        add(0,0,0,2,0, 0,0,0,2);
        add(1,0,40,2,0, 0,0,0,2);
        add(1,0,40,2,1, 0,0,0,2);
        add(0,0,0,2,0, 0,0,0,2);
        add(1,0,40,2,0, 0,0,0,2);
        add(0,0,0,2,0, 1,0,10,2);
        add(0,0,0,2,0, 0,0,0,2);
        // k=1 rounding
        add(0,0,0,1,0, 0,0,0,1);
        add(1,0,3,1,0, 0,0,0,1);
        add(1,0,0,1,0, 1,0,r1,1);
        add(0,0,0,1,0, 1,0,r1,1);
        add(0,0,0,1,1, 0,0,0,1);
        add(1,0,-3,1,0, 0,0,0,1);
        add(1,0,0,1,0, 1,0,r2,1);
        add(0,0,0,1,0, 1,0,r3,1);
        add(0,0,0,1,0, 0,0,0,1);
        // Clamp and k=0 pass-through
        add(0,0,0,7,0, 0,0,0,5);
        add(0,0,0,0,0, 0,0,0,0);
        add(1,1,-7,0,0, 0,0,0,0);
        add(1,1,5,0,0, 1,1,-7,0);
        add(0,0,0,0,0, 1,1,5,0);

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_ch    = '0;
        in_data  = '0;
        win_log2 = WLW'(DEFL);
        flush    = 1'b0;
        #8;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_ch", int'(out_ch), 0);
        check("rst_win_active", int'(win_active), DEFL);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive_cycle(tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].wl, tbl[i].fl);
            check($sformatf("tbl[%0d].valid", i), int'(out_valid), int'(tbl[i].ev));
            if (tbl[i].ev) begin
                check($sformatf("tbl[%0d].ch", i), int'(out_ch), tbl[i].ech);
                check($sformatf("tbl[%0d].data", i), int'(out_data), tbl[i].ed);
            end
            check($sformatf("tbl[%0d].win", i), int'(win_active), tbl[i].ew);
        end

        // Random traffic against the model
        wl_r = 2;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 39) == 0) wl_r = int'($urandom_range(0, 7));
            v_r  = ($urandom_range(0, 3) != 0);
            fl_r = ($urandom_range(0, 49) == 0);
            drive_cycle(v_r, int'($urandom_range(0, NCH-1)), int'($urandom_range(0, 4095)) - 2048, wl_r, fl_r);
        end
        for (int n = 0; n < 4; n++) drive_cycle(1'b0, 0, 0, wl_r, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
